// File: rtl/ser_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4-bit serializer among NREQ nibble requesters.
// Optional WAIT abort timeout is compiled in with `define SER_TX_ARBITER_TIMEOUT_EN.
module ser_tx_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [4*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic              ser_load,
   output logic [3:0]        ser_bits,
   input  logic              ser_finish,
   output logic              timeout_err
);

   localparam int unsigned PW = $clog2(NREQ);
   localparam int unsigned NW = 4;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

   state_t        state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] pick_c;
   logic [PW-1:0] cand_c;
   logic          pick_valid_c;
   logic          abort_c;

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
      $error("ser_tx_arbiter: NREQ or TIMEOUT out of range");
   end

   // First requesting index at or above ptr, wrapping at NREQ-1
   always_comb begin
      pick_c       = '0;
      cand_c       = '0;
      pick_valid_c = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand_c = PW'((32'(ptr) + k) % NREQ);
         if (!pick_valid_c && req[cand_c]) begin
            pick_c       = cand_c;
            pick_valid_c = 1'b1;
         end
      end
   end

`ifdef SER_TX_ARBITER_TIMEOUT_EN
   logic [7:0] wait_cnt;

   assign abort_c = (state == WAIT) && !ser_finish && (wait_cnt == 8'(TIMEOUT));

   // WAIT-cycle counter; zero on every entry to WAIT, abort flag lands in DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= abort_c;
         if (state == WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end
`else
   assign abort_c     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Sequencer: every output is a register updated on the state transition
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ptr      <= '0;
         win      <= '0;
         gnt      <= '0;
         done     <= '0;
         busy     <= 1'b0;
         ser_load <= 1'b0;
         ser_bits <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid_c) begin
                  state    <= LOAD;
                  win      <= pick_c;
                  gnt      <= NREQ'(1) << pick_c;
                  ser_load <= 1'b1;
                  ser_bits <= req_data[NW*32'(pick_c) +: NW];
                  busy     <= 1'b1;
               end
            end
            LOAD: begin
               // ser_finish still shows the previous transfer here, so it is not looked at
               state    <= WAIT;
               gnt      <= '0;
               ser_load <= 1'b0;
               ptr      <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
            end
            WAIT: begin
               if (ser_finish || abort_c) begin
                  state <= DONE;
                  done  <= NREQ'(1) << win;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= '0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ser_tx_arbiter.sv
// Directed bench for ser_tx_arbiter with a serializer model that raises finish
// 5 cycles after sampling ser_load and clears it when it samples ser_load.
module tb_ser_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] req_data;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        busy;
   logic        ser_load;
   logic [3:0]  ser_bits;
   logic        ser_finish;
   logic        timeout_err;

   logic        hold_low;
   int          mcnt;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   ser_tx_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_data    (req_data),
      .gnt         (gnt),
      .done        (done),
      .busy        (busy),
      .ser_load    (ser_load),
      .ser_bits    (ser_bits),
      .ser_finish  (ser_finish),
      .timeout_err (timeout_err)
   );

   // Serializer model; hold_low keeps finish from ever rising
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ser_finish <= 1'b0;
         mcnt       <= 0;
      end else if (ser_load) begin
         ser_finish <= 1'b0;
         mcnt       <= 5;
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1 && !hold_low) ser_finish <= 1'b1;
      end
   end

   task automatic wait_load(input int max, output int n, output bit ok);
      ok = 1'b0;
      n  = 0;
      while (!ok && n < max) begin
         @(negedge clk);
         n++;
         if (ser_load === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_done(input int max, output int n, output bit ok);
      ok = 1'b0;
      n  = 0;
      while (!ok && n < max) begin
         @(negedge clk);
         n++;
         if (done !== 4'b0000) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      req      = 4'b0000;
      req_data = 16'h0000;
      hold_low = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      total++; if (done !== 4'b0000) begin bad++; $display("FAIL reset_done: got %b want 0000", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (ser_load !== 1'b0) begin bad++; $display("FAIL reset_ser_load: got %b want 0", ser_load); end
      total++; if (ser_bits !== 4'h0) begin bad++; $display("FAIL reset_ser_bits: got %h want 0", ser_bits); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
      reset = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_single();
      int n;
      bit ok;
      req_data = 16'h555A;
      req      = 4'b0001;
      wait_load(10, n, ok);
      total++; if (!ok || n != 1) begin bad++; $display("FAIL single_latency: got ok=%0b n=%0d want ok=1 n=1", ok, n); end
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt: got %b want 0001", gnt); end
      total++; if (ser_bits !== 4'hA) begin bad++; $display("FAIL single_bits: got %h want a", ser_bits); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_load: got %b want 1", busy); end
      wait_done(40, n, ok);
      total++; if (!ok || n != 7) begin bad++; $display("FAIL single_done_time: got ok=%0b n=%0d want ok=1 n=7", ok, n); end
      total++; if (done !== 4'b0001) begin bad++; $display("FAIL single_done: got %b want 0001", done); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL single_terr: got %b want 0", timeout_err); end
      req = 4'b0000;
      @(negedge clk);
      total++; if (done !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL single_after: got done=%b busy=%b want 0000 0", done, busy); end
   endtask

   task automatic test_round_robin();
      logic [3:0] eg [5];
      logic [3:0] eb [5];
      int n;
      bit ok;
      eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      eb = '{4'h3, 4'h5, 4'h9, 4'hC, 4'h3};
      reset    = 1'b0;
      req      = 4'b1111;
      req_data = 16'hC953;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_load(10, n, ok);
         total++; if (!ok || gnt !== eg[i]) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, eg[i]); end
         total++; if (ser_bits !== eb[i]) begin bad++; $display("FAIL rr_bits[%0d]: got %h want %h", i, ser_bits, eb[i]); end
         wait_done(40, n, ok);
         total++; if (!ok || done !== eg[i]) begin bad++; $display("FAIL rr_done[%0d]: got %b want %b", i, done, eg[i]); end
      end
      req = 4'b0000;
   endtask

   task automatic test_ptr_skip();
      logic [3:0] eg [3];
      logic [3:0] eb [3];
      int n;
      bit ok;
      eg = '{4'b1000, 4'b0001, 4'b0010};
      eb = '{4'h8, 4'h1, 4'h2};
      req_data = 16'h8021;
      req      = 4'b0010;
      wait_load(10, n, ok);
      total++; if (!ok || gnt !== 4'b0010) begin bad++; $display("FAIL ptr_setup_gnt: got %b want 0010", gnt); end
      wait_done(40, n, ok);
      req = 4'b1011;
      for (int i = 0; i < 3; i++) begin
         wait_load(10, n, ok);
         total++; if (!ok || gnt !== eg[i]) begin bad++; $display("FAIL ptr_gnt[%0d]: got %b want %b", i, gnt, eg[i]); end
         total++; if (ser_bits !== eb[i]) begin bad++; $display("FAIL ptr_bits[%0d]: got %h want %h", i, ser_bits, eb[i]); end
         wait_done(40, n, ok);
         total++; if (!ok || done !== eg[i]) begin bad++; $display("FAIL ptr_done[%0d]: got %b want %b", i, done, eg[i]); end
      end
      req = 4'b0000;
   endtask

   task automatic test_reset_mid();
      int n;
      bit ok;
      req_data = 16'hE760;
      req      = 4'b0100;
      wait_load(10, n, ok);
      total++; if (!ok || gnt !== 4'b0100 || ser_bits !== 4'h7) begin bad++; $display("FAIL mid_first: got gnt=%b bits=%h want 0100 7", gnt, ser_bits); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (gnt !== 4'b0000 || done !== 4'b0000) begin bad++; $display("FAIL mid_async_gd: got gnt=%b done=%b want 0000 0000", gnt, done); end
      total++; if (busy !== 1'b0 || ser_load !== 1'b0) begin bad++; $display("FAIL mid_async_bl: got busy=%b load=%b want 0 0", busy, ser_load); end
      total++; if (ser_bits !== 4'h0 || timeout_err !== 1'b0) begin bad++; $display("FAIL mid_async_bt: got bits=%h terr=%b want 0 0", ser_bits, timeout_err); end
      repeat (2) begin
         @(negedge clk);
         total++; if (done !== 4'b0000) begin bad++; $display("FAIL mid_no_done: got %b want 0000", done); end
      end
      reset = 1'b1;
      wait_load(10, n, ok);
      total++; if (!ok || n != 1 || gnt !== 4'b0100) begin bad++; $display("FAIL mid_regrant: got n=%0d gnt=%b want 1 0100", n, gnt); end
      @(negedge clk);
      reset = 1'b0;
      req   = 4'b1010;
      @(negedge clk);
      reset = 1'b1;
      wait_load(10, n, ok);
      total++; if (!ok || gnt !== 4'b0010 || ser_bits !== 4'h6) begin bad++; $display("FAIL mid_ptr0: got gnt=%b bits=%h want 0010 6", gnt, ser_bits); end
      wait_done(40, n, ok);
      total++; if (!ok || n != 7 || done !== 4'b0010) begin bad++; $display("FAIL mid_done: got n=%0d done=%b want 7 0010", n, done); end
      req = 4'b0000;
   endtask

   task automatic test_stale_finish();
      int n;
      bit ok;
      req_data = 16'h0004;
      req      = 4'b0001;
      wait_load(10, n, ok);
      total++; if (!ok || gnt !== 4'b0001 || ser_bits !== 4'h4) begin bad++; $display("FAIL stale_gnt: got gnt=%b bits=%h want 0001 4", gnt, ser_bits); end
      @(negedge clk);
      total++; if (done !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL stale_wait: got done=%b busy=%b want 0000 1", done, busy); end
      wait_done(40, n, ok);
      total++; if (!ok || n != 6 || done !== 4'b0001) begin bad++; $display("FAIL stale_done: got n=%0d done=%b want 6 0001", n, done); end
      req = 4'b0000;
   endtask

   task automatic test_timeout();
      int n;
      bit ok;
      hold_low = 1'b1;
      req_data = 16'h0009;
      req      = 4'b0001;
      wait_load(10, n, ok);
      total++; if (!ok || gnt !== 4'b0001) begin bad++; $display("FAIL to_gnt: got %b want 0001", gnt); end
`ifdef SER_TX_ARBITER_TIMEOUT_EN
      wait_done(40, n, ok);
      total++; if (!ok || n != 18) begin bad++; $display("FAIL to_time: got ok=%0b n=%0d want ok=1 n=18", ok, n); end
      total++; if (done !== 4'b0001 || timeout_err !== 1'b1) begin bad++; $display("FAIL to_abort: got done=%b terr=%b want 0001 1", done, timeout_err); end
      req = 4'b0000;
      @(negedge clk);
      total++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL to_after: got terr=%b busy=%b want 0 0", timeout_err, busy); end
`else
      wait_done(40, n, ok);
      total++; if (ok) begin bad++; $display("FAIL to_no_done: got done=%b at n=%0d want none", done, n); end
      total++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL to_stuck: got busy=%b terr=%b want 1 0", busy, timeout_err); end
      req   = 4'b0000;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
`endif
      hold_low = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_ptr_skip();
      test_reset_mid();
      test_stale_finish();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
